// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered adder between two requesters.
// Each requester has a valid/ready request channel and a valid/ready response channel.

module adder_arbiter_add #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o
);
   logic [WIDTH:0] full_sum;

   assign full_sum = {1'b0, a_i} + {1'b0, b_i};
   assign sum_o    = full_sum[WIDTH-1:0];
   assign carry_o  = full_sum[WIDTH];
endmodule

module adder_arbiter #(
   parameter int ADDER_WIDTH = 32
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   REQ0_VALID,
   input  logic [ADDER_WIDTH-1:0] REQ0_A,
   input  logic [ADDER_WIDTH-1:0] REQ0_B,
   output logic                   REQ0_READY,
   input  logic                   REQ1_VALID,
   input  logic [ADDER_WIDTH-1:0] REQ1_A,
   input  logic [ADDER_WIDTH-1:0] REQ1_B,
   output logic                   REQ1_READY,
   output logic                   RSP0_VALID,
   input  logic                   RSP0_READY,
   output logic                   RSP1_VALID,
   input  logic                   RSP1_READY,
   output logic [ADDER_WIDTH-1:0] RSP_SUM,
   output logic                   RSP_CARRY
);
   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic                   owner_q, owner_d;
   logic                   prio_q, prio_d;
   logic [ADDER_WIDTH-1:0] sum_q, sum_d;
   logic                   carry_q, carry_d;

   logic                   rsp_full;
   logic                   grant0, grant1;
   logic                   drain, can_accept, accept;
   logic [ADDER_WIDTH-1:0] op_a, op_b, add_sum;
   logic                   add_carry;

   assign rsp_full = (state_q == S_FULL);

   // Both valid: PRIO picks the winner; otherwise the lone requester wins.
   assign grant0 = REQ0_VALID & (~REQ1_VALID | ~prio_q);
   assign grant1 = REQ1_VALID & (~REQ0_VALID | prio_q);

   assign drain      = rsp_full & (owner_q ? RSP1_READY : RSP0_READY);
   assign can_accept = ~rsp_full | drain;

   assign REQ0_READY = grant0 & can_accept;
   assign REQ1_READY = grant1 & can_accept;
   assign accept     = (REQ0_VALID & REQ0_READY) | (REQ1_VALID & REQ1_READY);

   assign op_a = grant1 ? REQ1_A : REQ0_A;
   assign op_b = grant1 ? REQ1_B : REQ0_B;

   adder_arbiter_add #(.WIDTH(ADDER_WIDTH)) u_add (
      .a_i     (op_a),
      .b_i     (op_b),
      .sum_o   (add_sum),
      .carry_o (add_carry)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      prio_d  = prio_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      case (state_q)
         S_EMPTY: if (accept) state_d = S_FULL;
         S_FULL:  if (drain && !accept) state_d = S_EMPTY;
         default: state_d = S_EMPTY;
      endcase
      if (accept) begin
         sum_d   = add_sum;
         carry_d = add_carry;
         owner_d = grant1;
         prio_d  = ~grant1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_EMPTY;
         owner_q <= 1'b0;
         prio_q  <= 1'b0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         prio_q  <= prio_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   assign RSP0_VALID = rsp_full & ~owner_q;
   assign RSP1_VALID = rsp_full & owner_q;
   assign RSP_SUM    = sum_q;
   assign RSP_CARRY  = carry_q;
endmodule
